// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: control codes, op classes, opcodes, FSM states.
// Optional multiplier support is enabled by defining ALU_MUL_EN.
package alu_pkg;

    typedef enum logic [3:0] {
        CTRL_AND  = 4'b0000,
        CTRL_OR   = 4'b0001,
        CTRL_ADD  = 4'b0010,
        CTRL_SUB  = 4'b0110,
        CTRL_SLT  = 4'b0111,
        CTRL_XOR  = 4'b1000,
        CTRL_SLL  = 4'b1001,
        CTRL_SRL  = 4'b1010,
        CTRL_SRA  = 4'b1011,
        CTRL_SLTU = 4'b1100,
        CTRL_MUL  = 4'b1101,
        CTRL_ILL  = 4'b1111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        AOP_LDST = 2'b00,
        AOP_BR   = 2'b01,
        AOP_RJ   = 2'b10,
        AOP_IMM  = 2'b11
    } alu_op_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    typedef struct packed {
        alu_ctrl_e ctrl;
        alu_op_e   op;
        logic      a_pc;     // operand A is pc instead of rs1
        logic      b_imm;    // operand B is imm instead of rs2
        logic      is_br;
        logic      br_inv;   // BNE/BGE/BGEU: taken is the inverse of the compare
        logic      clr_lsb;
        logic      illegal;
    } dec_t;

    function automatic logic is_shift_ctrl(input alu_ctrl_e c);
        return (c == CTRL_SLL) || (c == CTRL_SRL) || (c == CTRL_SRA);
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of opcode/func3/func7/imm[10] into ALU control, class and operand selects.
// MUL decode exists only when ALU_MUL_EN is defined.
module alu_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       imm10,
    output dec_t       dec
);

    always_comb begin
        dec = '{ctrl: CTRL_ADD, op: AOP_LDST, a_pc: 1'b0, b_imm: 1'b1,
                is_br: 1'b0, br_inv: 1'b0, clr_lsb: 1'b0, illegal: 1'b0};
        case (opcode)
            OP_R: begin
                dec.op    = AOP_RJ;
                dec.b_imm = 1'b0;
                if (func7 == 7'b0000001) begin
`ifdef ALU_MUL_EN
                    if (func3 == 3'b000) dec.ctrl = CTRL_MUL;
                    else                 dec.illegal = 1'b1;
`else
                    dec.illegal = 1'b1;
`endif
                end else begin
                    case (func3)
                        3'b000:  dec.ctrl = func7[5] ? CTRL_SUB : CTRL_ADD;
                        3'b001:  dec.ctrl = CTRL_SLL;
                        3'b010:  dec.ctrl = CTRL_SLT;
                        3'b011:  dec.ctrl = CTRL_SLTU;
                        3'b100:  dec.ctrl = CTRL_XOR;
                        3'b101:  dec.ctrl = func7[5] ? CTRL_SRA : CTRL_SRL;
                        3'b110:  dec.ctrl = CTRL_OR;
                        default: dec.ctrl = CTRL_AND;
                    endcase
                end
            end
            OP_I: begin
                dec.op = AOP_IMM;
                case (func3)
                    3'b000:  dec.ctrl = CTRL_ADD;
                    3'b001:  dec.ctrl = CTRL_SLL;
                    3'b010:  dec.ctrl = CTRL_SLT;
                    3'b011:  dec.ctrl = CTRL_SLTU;
                    3'b100:  dec.ctrl = CTRL_XOR;
                    3'b101:  dec.ctrl = imm10 ? CTRL_SRA : CTRL_SRL;
                    3'b110:  dec.ctrl = CTRL_OR;
                    default: dec.ctrl = CTRL_AND;
                endcase
            end
            OP_LOAD, OP_STORE: dec.ctrl = CTRL_ADD;
            OP_BRANCH: begin
                dec.op     = AOP_BR;
                dec.b_imm  = 1'b0;
                dec.is_br  = 1'b1;
                dec.br_inv = func3[0];
                case (func3[2:1])
                    2'b00:   dec.ctrl = CTRL_SUB;
                    2'b10:   dec.ctrl = CTRL_SLT;
                    2'b11:   dec.ctrl = CTRL_SLTU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_JAL, OP_AUIPC: begin
                dec.op   = AOP_RJ;
                dec.a_pc = 1'b1;
            end
            OP_JALR: begin
                dec.op      = AOP_RJ;
                dec.clr_lsb = 1'b1;
                dec.illegal = (func3 != 3'b000);
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.ctrl    = CTRL_ILL;
            dec.op      = AOP_LDST;
            dec.is_br   = 1'b0;
            dec.clr_lsb = 1'b0;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops, iterative shifter, registered result over valid/ready.
// Define ALU_MUL_EN to add the single-cycle MUL datapath.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [3:0]      alu_ctrl,
    output logic [1:0]      alu_op,
    output logic            zero,
    output logic            illegal
);

    localparam int SW = $clog2(XLEN);

    dec_t dec;

    alu_decode u_decode (
        .opcode (opcode),
        .func3  (func3),
        .func7  (func7),
        .imm10  (imm[10]),
        .dec    (dec)
    );

    state_e          state_q, state_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [SW-1:0]   rem_q, rem_d;
    alu_ctrl_e       sh_ctrl_q, sh_ctrl_d;
    alu_op_e         sh_op_q, sh_op_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    alu_ctrl_e       ctrl_q, ctrl_d;
    alu_op_e         op_q, op_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;

    logic [XLEN-1:0] op_a, op_b, raw, res, work_sh;
    logic [SW-1:0]   shamt, step;
    logic            is_shift;

    assign in_ready = !reset && (state_q == S_IDLE) && (!out_valid_q || out_ready);

    always_comb begin
        op_a     = dec.a_pc ? pc : rs1_val;
        op_b     = dec.b_imm ? imm : rs2_val;
        shamt    = op_b[SW-1:0];
        is_shift = !dec.illegal && is_shift_ctrl(dec.ctrl);
        case (dec.ctrl)
            CTRL_AND:  raw = op_a & op_b;
            CTRL_OR:   raw = op_a | op_b;
            CTRL_ADD:  raw = op_a + op_b;
            CTRL_SUB:  raw = op_a - op_b;
            CTRL_XOR:  raw = op_a ^ op_b;
            CTRL_SLT:  raw = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            CTRL_SLTU: raw = {{(XLEN-1){1'b0}}, op_a < op_b};
            // shifts only complete here when the amount is zero
            CTRL_SLL, CTRL_SRL, CTRL_SRA: raw = op_a;
`ifdef ALU_MUL_EN
            CTRL_MUL:  raw = op_a * op_b;
`endif
            default:   raw = '0;
        endcase
        res = raw;
        if (dec.is_br)
            res = {{(XLEN-1){1'b0}}, dec.br_inv ^ ((dec.ctrl == CTRL_SUB) ? (raw == '0) : raw[0])};
        if (dec.clr_lsb) res[0] = 1'b0;
        if (dec.illegal) res = '0;
    end

    always_comb begin
        step = (int'({1'b0, rem_q}) > SHIFT_STEP) ? SW'(SHIFT_STEP) : rem_q;
        case (sh_ctrl_q)
            CTRL_SLL: work_sh = work_q << step;
            CTRL_SRA: work_sh = $signed(work_q) >>> step;
            default:  work_sh = work_q >> step;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        rem_d       = rem_q;
        sh_ctrl_d   = sh_ctrl_q;
        sh_op_d     = sh_op_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        ctrl_d      = ctrl_q;
        op_d        = op_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    if (is_shift && (shamt != '0)) begin
                        state_d   = S_SHIFT;
                        work_d    = op_a;
                        rem_d     = shamt;
                        sh_ctrl_d = dec.ctrl;
                        sh_op_d   = dec.op;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = res;
                        ctrl_d      = dec.ctrl;
                        op_d        = dec.op;
                        zero_d      = (res == '0);
                        illegal_d   = dec.illegal;
                    end
                end
            end
            S_SHIFT: begin
                // the final cycle (remaining==0) only publishes, giving 1+ceil(shamt/step) latency
                if (rem_q != '0) begin
                    work_d = work_sh;
                    rem_d  = rem_q - step;
                end else begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = work_q;
                    ctrl_d      = sh_ctrl_q;
                    op_d        = sh_op_q;
                    zero_d      = (work_q == '0);
                    illegal_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            rem_q       <= '0;
            sh_ctrl_q   <= CTRL_AND;
            sh_op_q     <= AOP_LDST;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ctrl_q      <= CTRL_AND;
            op_q        <= AOP_LDST;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            rem_q       <= rem_d;
            sh_ctrl_q   <= sh_ctrl_d;
            sh_op_q     <= sh_op_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ctrl_q      <= ctrl_d;
            op_q        <= op_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign alu_ctrl  = ctrl_q;
    assign alu_op    = op_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit (XLEN=32, SHIFT_STEP=1): directed vectors, hand-computed results.
module tb_alu_exec_unit;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] I   = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] JR  = 7'b1100111;
    localparam logic [6:0] AUI = 7'b0010111;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  ctrl;
        logic [1:0]  op;
        logic        chk_op;
        logic        z;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [6:0]  opcode = '0, func7 = '0;
    logic [2:0]  func3 = '0;
    logic [31:0] rs1_val = '0, rs2_val = '0, imm = '0, pc = '0, result;
    logic [3:0]  alu_ctrl;
    logic [1:0]  alu_op;
    logic        zero, illegal;

    int   errors = 0, checks = 0, cyc = 0, acc_cyc = 0;
    int   n_out = 0, last_out_cyc = 0, prev_out_cyc = 0, n_before;
    exp_t sb[$];
    exp_t me;

    alu_exec_unit #(.XLEN(32), .SHIFT_STEP(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .func3(func3), .func7(func7),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .alu_ctrl(alu_ctrl), .alu_op(alu_op), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic fail_to(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got timeout, want event", nm);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_out++;
            prev_out_cyc = last_out_cyc;
            last_out_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result %0h, want no output", result);
            end else begin
                me = sb.pop_front();
                chk("result", result, me.res);
                chk("alu_ctrl", 32'(alu_ctrl), 32'(me.ctrl));
                if (me.chk_op) chk("alu_op", 32'(alu_op), 32'(me.op));
                chk("zero", 32'(zero), 32'(me.z));
                chk("illegal", 32'(illegal), 32'(me.ill));
            end
        end
    end

    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [31:0] p, input logic [31:0] eres, input logic [3:0] ectrl,
                         input logic [1:0] eop, input logic eill, input logic push);
        exp_t e;
        logic done;
        e = '{res: eres, ctrl: ectrl, op: eop, chk_op: !eill && (opc != ST),
              z: (eres == 32'd0), ill: eill};
        opcode = opc; func3 = f3; func7 = f7;
        rs1_val = a; rs2_val = b; imm = im; pc = p;
        in_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (push) sb.push_back(e);
                acc_cyc = cyc + 1;
                done = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        if (!done) fail_to("accept");
    endtask

    task automatic op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                      input logic [31:0] p, input logic [31:0] eres, input logic [3:0] ectrl,
                      input logic [1:0] eop, input logic eill);
        issue(opc, f3, f7, a, b, im, p, eres, ectrl, eop, eill, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            fail_to("drain");
            sb.delete();
        end
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // back-to-back ADD then SUB
        op(R, 3'b000, 7'b0000000, 32'd7, 32'd5, 32'd0, 32'd0, 32'd12, 4'b0010, 2'b10, 1'b0);
        op(R, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFE, 4'b0110, 2'b10, 1'b0);
        drain();
        chk("b2b_spacing", 32'(last_out_cyc - prev_out_cyc), 32'd1);

        // iterative SRA by 4
        @(posedge clk); #1;
        op(R, 3'b101, 7'b0100000, 32'h80000000, 32'd4, 32'd0, 32'd0, 32'hF8000000, 4'b1011, 2'b10, 1'b0);
        @(negedge clk);
        chk("shift_in_ready", 32'(in_ready), 32'd0);
        drain();
        chk("sra_latency", 32'(last_out_cyc - acc_cyc), 32'd5);

        // branches and assorted single-cycle / shift vectors
        @(posedge clk); #1;
        op(BR, 3'b110, 7'd0, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd1, 4'b1100, 2'b01, 1'b0);
        op(BR, 3'b100, 7'd0, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 4'b0111, 2'b01, 1'b0);
        op(BR, 3'b101, 7'd0, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd1, 4'b0111, 2'b01, 1'b0);
        op(BR, 3'b000, 7'd0, 32'd5, 32'd5, 32'd0, 32'd0, 32'd1, 4'b0110, 2'b01, 1'b0);
        op(BR, 3'b001, 7'd0, 32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 4'b0110, 2'b01, 1'b0);
        op(I, 3'b000, 7'b0100000, 32'd10, 32'd0, 32'hFFFFFFFD, 32'd0, 32'd7, 4'b0010, 2'b11, 1'b0);
        op(I, 3'b011, 7'd0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd1, 4'b1100, 2'b11, 1'b0);
        op(I, 3'b100, 7'd0, 32'hFF, 32'd0, 32'h0F, 32'd0, 32'hF0, 4'b1000, 2'b11, 1'b0);
        op(I, 3'b110, 7'd0, 32'hF0, 32'd0, 32'h0F, 32'd0, 32'hFF, 4'b0001, 2'b11, 1'b0);
        op(I, 3'b111, 7'd0, 32'hF0, 32'd0, 32'h3C, 32'd0, 32'h30, 4'b0000, 2'b11, 1'b0);
        op(R, 3'b010, 7'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd1, 4'b0111, 2'b10, 1'b0);
        op(I, 3'b001, 7'd0, 32'h1234, 32'd0, 32'd0, 32'd0, 32'h1234, 4'b1001, 2'b11, 1'b0);
        op(I, 3'b101, 7'd0, 32'h80, 32'd0, 32'd3, 32'd0, 32'h10, 4'b1010, 2'b11, 1'b0);
        op(I, 3'b101, 7'd0, 32'hFFFFFF00, 32'd0, 32'h402, 32'd0, 32'hFFFFFFC0, 4'b1011, 2'b11, 1'b0);
        op(LD, 3'b010, 7'd0, 32'h100, 32'd0, 32'hFFFFFFFC, 32'd0, 32'hFC, 4'b0010, 2'b00, 1'b0);
        op(ST, 3'b010, 7'd0, 32'h200, 32'd0, 32'd8, 32'd0, 32'h208, 4'b0010, 2'b00, 1'b0);
        op(AUI, 3'b000, 7'd0, 32'd0, 32'd0, 32'h2000, 32'h1000, 32'h3000, 4'b0010, 2'b10, 1'b0);
        op(JAL, 3'b000, 7'd0, 32'd0, 32'd0, 32'hFFFFFFF0, 32'h1000, 32'hFF0, 4'b0010, 2'b10, 1'b0);
        op(JR, 3'b000, 7'd0, 32'h1001, 32'd0, 32'd4, 32'd0, 32'h1004, 4'b0010, 2'b10, 1'b0);
        op(7'b0000000, 3'b000, 7'd0, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 4'b1111, 2'b00, 1'b1);
        op(BR, 3'b010, 7'd0, 32'd3, 32'd3, 32'd0, 32'd0, 32'd0, 4'b1111, 2'b00, 1'b1);
`ifdef ALU_MUL_EN
        op(R, 3'b000, 7'b0000001, 32'd6, 32'd7, 32'd0, 32'd0, 32'd42, 4'b1101, 2'b10, 1'b0);
`else
        op(R, 3'b000, 7'b0000001, 32'd6, 32'd7, 32'd0, 32'd0, 32'd0, 4'b1111, 2'b00, 1'b1);
`endif
        drain();

        // output hold under back-pressure, then accept + handover on one edge
        @(posedge clk); #1 out_ready = 1'b0;
        op(R, 3'b100, 7'd0, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 32'hFF00, 4'b1000, 2'b10, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", result, 32'hFF00);
            chk("hold_ctrl", 32'(alu_ctrl), 32'b1000);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        op(R, 3'b000, 7'd0, 32'd1, 32'd1, 32'd0, 32'd0, 32'd2, 4'b0010, 2'b10, 1'b0);
        drain();
        chk("handover_spacing", 32'(last_out_cyc - prev_out_cyc), 32'd1);

        // reset in the middle of a shift discards it
        @(posedge clk); #1;
        issue(R, 3'b001, 7'd0, 32'd1, 32'd10, 32'd0, 32'd0, 32'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_ctrl", 32'(alu_ctrl), 32'd0);
        chk("mid_rst_op", 32'(alu_op), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        n_before = n_out;
        repeat (15) @(negedge clk);
        chk("no_stale_output", 32'(n_out), 32'(n_before));
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        op(R, 3'b000, 7'd0, 32'd20, 32'd22, 32'd0, 32'd0, 32'd42, 4'b0010, 2'b10, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
